// File: rtl/csr_pkg.sv
// csr_pkg: CSR numbers, write masks, exception codes and field positions for csr_unit.
package csr_pkg;
  localparam logic [13:0] CSR_CRMD   = 14'h00;
  localparam logic [13:0] CSR_PRMD   = 14'h01;
  localparam logic [13:0] CSR_ECFG   = 14'h04;
  localparam logic [13:0] CSR_ESTAT  = 14'h05;
  localparam logic [13:0] CSR_ERA    = 14'h06;
  localparam logic [13:0] CSR_BADV   = 14'h07;
  localparam logic [13:0] CSR_EENTRY = 14'h0c;
  localparam logic [13:0] CSR_SAVE0  = 14'h30;
  localparam logic [13:0] CSR_TID    = 14'h40;
  localparam logic [13:0] CSR_TCFG   = 14'h41;
  localparam logic [13:0] CSR_TVAL   = 14'h42;
  localparam logic [13:0] CSR_TICLR  = 14'h44;
  localparam logic [31:0] WM_CRMD    = 32'h0000_0007;
  localparam logic [31:0] WM_PRMD    = 32'h0000_0007;
  localparam logic [31:0] WM_ECFG    = 32'h0000_1bff;
  localparam logic [31:0] WM_ESTAT   = 32'h0000_0003;
  localparam logic [31:0] WM_EENTRY  = 32'hffff_ffc0;
  localparam logic [31:0] CRMD_RST   = 32'h0000_0008;
  localparam logic [5:0]  ECODE_ADE  = 6'h08;
  localparam logic [5:0]  ECODE_ALE  = 6'h09;
  localparam logic [5:0]  ECODE_SYS  = 6'h0b;
  localparam int CRMD_IE     = 2;
  localparam int PRMD_PIE    = 2;
  localparam int ESTAT_TI    = 11;
  localparam int ESTAT_ECODE = 16;
  localparam int ESTAT_ESUB  = 22;
  localparam int TCFG_EN     = 0;
  localparam int TCFG_PER    = 1;
  function automatic logic [31:0] csr_wr(input logic [31:0] old, input logic [31:0] wv, input logic [31:0] m);
    return (old & ~m) | (wv & m);
  endfunction
endpackage

// File: rtl/csr_timer.sv
// csr_timer: TVAL countdown with IDLE/RUN FSM; timer_fire is high while running at zero.
module csr_timer
  import csr_pkg::*;
#(
  parameter int TIMER_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   tcfg_we,
  input  logic [TIMER_WIDTH-3:0] wr_init,
  input  logic                   wr_en,
  input  logic [TIMER_WIDTH-3:0] init,
  input  logic                   periodic,
  output logic [TIMER_WIDTH-1:0] tval,
  output logic                   timer_fire
);
  localparam logic IDLE = 1'b0;
  localparam logic RUN  = 1'b1;
  logic state_q, state_d;
  logic [TIMER_WIDTH-1:0] tval_q, tval_d;
  always_comb begin
    timer_fire = state_q == RUN && tval_q == '0;
    state_d = state_q;
    tval_d = tval_q;
    if (tcfg_we) begin
      tval_d = {wr_init, 2'b00};
      state_d = wr_en ? RUN : IDLE;
    end else if (state_q == RUN) begin
      tval_d = timer_fire ? (periodic ? {init, 2'b00} : '0) : tval_q - TIMER_WIDTH'(1);
      state_d = timer_fire && !periodic ? IDLE : RUN;
    end
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q <= IDLE;
      tval_q <= '0;
    end else begin
      state_q <= state_d;
      tval_q <= tval_d;
    end
  assign tval = tval_q;
endmodule

// File: rtl/csr_unit.sv
// csr_unit: WB-stage CSR file with exception entry/return and interrupt sources.
// CSR_TIMER_EN adds TCFG/TVAL/TICLR and the countdown timer.
module csr_unit
  import csr_pkg::*;
#(
  parameter int SAVE_NUM    = 4,
  parameter int TIMER_WIDTH = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        csr_re,
  input  logic [13:0] csr_num,
  output logic [31:0] csr_rvalue,
  input  logic        csr_we,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wvalue,
  input  logic        wb_ex,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_vaddr,
  input  logic        ertn_flush,
  input  logic [7:0]  hw_int_in,
  input  logic [31:0] coreid_in,
  output logic [31:0] csr_eentry,
  output logic [31:0] csr_era,
  output logic        has_int
);
  logic [31:0] crmd_q, crmd_d, prmd_q, prmd_d, ecfg_q, ecfg_d, estat_q, estat_d;
  logic [31:0] era_q, era_d, badv_q, badv_d, eentry_q, eentry_d, tid_q, tid_d;
  logic [31:0] save_q [SAVE_NUM];
  logic [31:0] save_d [SAVE_NUM];
  logic [31:0] wm, rv;
  logic we, ti;
  // lower-priority events in an exception/ertn cycle are dropped
  assign we = csr_we & ~wb_ex & ~ertn_flush;
  assign wm = we ? csr_wmask : '0;
`ifdef CSR_TIMER_EN
  logic [31:0] tcfg_q, tcfg_d;
  logic [TIMER_WIDTH-1:0] tval;
  logic tcfg_we, fire, ticlr;
  assign tcfg_we = we && csr_num == CSR_TCFG;
  assign ticlr = we && csr_num == CSR_TICLR && csr_wmask[0] && csr_wvalue[0];
  assign tcfg_d = tcfg_we ? csr_wr(tcfg_q, csr_wvalue, csr_wmask) : tcfg_q;
  assign ti = fire | (estat_q[ESTAT_TI] & ~ticlr);
  csr_timer #(.TIMER_WIDTH(TIMER_WIDTH)) u_timer (
    .clk       (clk),
    .resetn    (resetn),
    .tcfg_we   (tcfg_we),
    .wr_init   (tcfg_d[TIMER_WIDTH-1:2]),
    .wr_en     (tcfg_d[TCFG_EN]),
    .init      (tcfg_q[TIMER_WIDTH-1:2]),
    .periodic  (tcfg_q[TCFG_PER]),
    .tval      (tval),
    .timer_fire(fire)
  );
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) tcfg_q <= '0;
    else tcfg_q <= tcfg_d;
`else
  assign ti = 1'b0;
`endif
  always_comb begin
    rv = '0;
    case (csr_num)
      CSR_CRMD:   rv = crmd_q;
      CSR_PRMD:   rv = prmd_q;
      CSR_ECFG:   rv = ecfg_q;
      CSR_ESTAT:  rv = estat_q;
      CSR_ERA:    rv = era_q;
      CSR_BADV:   rv = badv_q;
      CSR_EENTRY: rv = eentry_q;
      CSR_TID:    rv = tid_q;
`ifdef CSR_TIMER_EN
      CSR_TCFG:   rv = tcfg_q;
      CSR_TVAL:   rv = 32'(tval);
`endif
      default:    rv = '0;
    endcase
    for (int i = 0; i < SAVE_NUM; i++)
      if (csr_num == CSR_SAVE0 + 14'(i)) rv = save_q[i];
    csr_rvalue = csr_re ? rv : '0;
  end
  always_comb begin
    crmd_d   = csr_wr(crmd_q, csr_wvalue, csr_num == CSR_CRMD ? wm & WM_CRMD : '0);
    prmd_d   = csr_wr(prmd_q, csr_wvalue, csr_num == CSR_PRMD ? wm & WM_PRMD : '0);
    ecfg_d   = csr_wr(ecfg_q, csr_wvalue, csr_num == CSR_ECFG ? wm & WM_ECFG : '0);
    estat_d  = csr_wr(estat_q, csr_wvalue, csr_num == CSR_ESTAT ? wm & WM_ESTAT : '0);
    era_d    = csr_wr(era_q, csr_wvalue, csr_num == CSR_ERA ? wm : '0);
    badv_d   = csr_wr(badv_q, csr_wvalue, csr_num == CSR_BADV ? wm : '0);
    eentry_d = csr_wr(eentry_q, csr_wvalue, csr_num == CSR_EENTRY ? wm & WM_EENTRY : '0);
    tid_d    = csr_wr(tid_q, csr_wvalue, csr_num == CSR_TID ? wm : '0);
    for (int i = 0; i < SAVE_NUM; i++)
      save_d[i] = csr_wr(save_q[i], csr_wvalue, csr_num == CSR_SAVE0 + 14'(i) ? wm : '0);
    if (wb_ex) begin
      prmd_d[2:0] = crmd_q[2:0];
      crmd_d[2:0] = 3'b000;
      era_d = wb_pc;
      estat_d[ESTAT_ECODE +: 6] = wb_ecode;
      estat_d[ESTAT_ESUB +: 9] = wb_esubcode;
      badv_d = wb_ecode == ECODE_ADE ? wb_pc : wb_ecode == ECODE_ALE ? wb_vaddr : badv_q;
    end else if (ertn_flush) begin
      crmd_d[2:0] = prmd_q[2:0];
    end
    estat_d[9:2] = hw_int_in;
    estat_d[10] = 1'b0;
    estat_d[ESTAT_TI] = ti;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      crmd_q <= CRMD_RST;
      prmd_q <= '0;
      ecfg_q <= '0;
      estat_q <= '0;
      era_q <= '0;
      badv_q <= '0;
      eentry_q <= '0;
      tid_q <= coreid_in;
      for (int i = 0; i < SAVE_NUM; i++) save_q[i] <= '0;
    end else begin
      crmd_q <= crmd_d;
      prmd_q <= prmd_d;
      ecfg_q <= ecfg_d;
      estat_q <= estat_d;
      era_q <= era_d;
      badv_q <= badv_d;
      eentry_q <= eentry_d;
      tid_q <= tid_d;
      for (int i = 0; i < SAVE_NUM; i++) save_q[i] <= save_d[i];
    end
  assign csr_eentry = eentry_q;
  assign csr_era = era_q;
  assign has_int = crmd_q[CRMD_IE] & |(estat_q[12:0] & ecfg_q[12:0]);
endmodule
